// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared configuration and stage-record layout for the pipelined ripple-carry
// adder. The adder width and pipeline depth live here so the slice width, the
// stage record and the slice-placement helper all agree with each other.
// Changing the adder configuration means editing ADDER_WIDTH / ADDER_STAGES.
//
// Contents
//   ADDER_WIDTH   operand/sum width in bits
//   ADDER_STAGES  number of carry slices (= pipeline depth)
//   SLICE         bits added per stage
//   SLICE_OK      configuration sanity flag, checked at elaboration by the top
//   stage_t       one pipeline register bank
//   placeSlice    puts a finished sum slice into the top SLICE bits of a word
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int ADDER_WIDTH  = 16;
   localparam int ADDER_STAGES = 4;
   localparam int SLICE        = ADDER_WIDTH / ADDER_STAGES;

   // The carry chain must split into equal slices.
   localparam bit SLICE_OK = (ADDER_STAGES > 0) && ((ADDER_WIDTH % ADDER_STAGES) == 0);

   // One stage register bank.
   //   aPend/bPend : operand bits not yet added, already shifted so that the
   //                 next slice to add sits in the low SLICE bits
   //   sumDone     : finished sum slices, shifted down one slice per stage so
   //                 that after the last stage they line up at bit 0
   //   carry       : carry out of the slice added in this stage
   //   ovf         : signed-overflow flag of the slice added in this stage;
   //                 only the last stage's value is meaningful
   typedef struct packed {
      logic                   valid;
      logic                   carry;
      logic                   ovf;
      logic [ADDER_WIDTH-1:0] aPend;
      logic [ADDER_WIDTH-1:0] bPend;
      logic [ADDER_WIDTH-1:0] sumDone;
   } stage_t;

   function automatic logic [ADDER_WIDTH-1:0] placeSlice(input logic [SLICE-1:0] s);
      logic [ADDER_WIDTH-1:0] w;
      w = '0;
      w[ADDER_WIDTH-1 -: SLICE] = s;
      return w;
   endfunction

endpackage

// File: rtl/rca_slice.sv
// -----------------------------------------------------------------------------
// full_adder / rca_slice
// full_adder : one-bit full adder cell.
// rca_slice  : combinational W-bit ripple-carry adder built as a generate
//              chain of full_adder cells.
//
// rca_slice ports
//   a_i, b_i     W-bit operand slices
//   cin_i        carry into bit 0 of the slice
//   sum_o        W-bit slice sum
//   cout_o       carry out of the slice MSB
//   carryMsb_o   carry into the slice MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module rca_slice
   import adder_pkg::*;
#(
   parameter int W = SLICE
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o,
   output logic         carryMsb_o
);

   // carry[i] is the carry into bit i; carry[W] leaves the slice.
   logic [W:0] carry;

   assign carry[0] = cin_i;

   for (genvar i = 0; i < W; i++) begin : gBit
      full_adder uFa (
         .a_i   (a_i[i]),
         .b_i   (b_i[i]),
         .cin_i (carry[i]),
         .sum_o (sum_o[i]),
         .cout_o(carry[i+1])
      );
   end

   assign cout_o     = carry[W];
   assign carryMsb_o = carry[W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// -----------------------------------------------------------------------------
// pipelined_rca_adder
// Pipelined ripple-carry adder. The WIDTH-bit carry chain is cut into STAGES
// equal slices; stage k adds slice k and registers the result, so the longest
// combinational path is one SLICE-bit ripple. One operand pair is accepted per
// cycle with valid/ready flow control; latency is STAGES cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a, b, cin valid this cycle
//   in_ready   adder accepts input this cycle (low only while stalled)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry into bit 0
//   out_valid  sum, cout, ovf valid
//   out_ready  consumer accepts the output this cycle
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module pipelined_rca_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = ADDER_WIDTH,
   parameter int STAGES = ADDER_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // The stage record is sized by the package, so the instance parameters
   // must match it and the chain must split evenly.
   if (!SLICE_OK || (WIDTH != ADDER_WIDTH) || (STAGES != ADDER_STAGES)) begin : gCfgCheck
      $error("pipelined_rca_adder: WIDTH/STAGES must match adder_pkg and WIDTH %% STAGES must be 0");
   end

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];
   stage_t prevRec [STAGES];
   stage_t inRec;

   logic [STAGES-1:0][SLICE-1:0] sliceSum;
   logic [STAGES-1:0]            sliceCout;
   logic [STAGES-1:0]            sliceCmsb;
   logic                         stall;

   // The input port is presented as a virtual stage -1 record: nothing added
   // yet, operands unshifted, cin in the carry field. Every stage then reads
   // its operands and carry from the record feeding it in the same way.
   always_comb begin
      inRec       = '0;
      inRec.valid = in_valid;
      inRec.carry = cin;
      inRec.aPend = a;
      inRec.bPend = b;
      prevRec[0]  = inRec;
      for (int k = 1; k < STAGES; k++) begin
         prevRec[k] = stage_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : gSlice
      rca_slice #(.W(SLICE)) uSlice (
         .a_i       (prevRec[k].aPend[SLICE-1:0]),
         .b_i       (prevRec[k].bPend[SLICE-1:0]),
         .cin_i     (prevRec[k].carry),
         .sum_o     (sliceSum[k]),
         .cout_o    (sliceCout[k]),
         .carryMsb_o(sliceCmsb[k])
      );
   end

   // Each stage consumes the low slice of the pending operands, shifts the
   // rest down, and inserts its finished sum slice at the top of sumDone
   // while shifting earlier slices down. After the last stage the slices
   // have reached their final bit positions.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         stage_d[k]         = '0;
         stage_d[k].valid   = prevRec[k].valid;
         stage_d[k].carry   = sliceCout[k];
         stage_d[k].ovf     = sliceCmsb[k] ^ sliceCout[k];
         stage_d[k].aPend   = prevRec[k].aPend >> SLICE;
         stage_d[k].bPend   = prevRec[k].bPend >> SLICE;
         stage_d[k].sumDone = (prevRec[k].sumDone >> SLICE) | placeSlice(sliceSum[k]);
      end
   end

   // A result waiting on a consumer freezes the whole pipe; ready is the
   // combinational complement so an input is never accepted into a frozen pipe.
   assign stall    = stage_q[STAGES-1].valid && !out_ready;
   assign in_ready = !stall;

   // Stage register banks; reset discards everything in flight and wins over
   // any transfer in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign out_valid = stage_q[STAGES-1].valid;
   assign sum       = stage_q[STAGES-1].sumDone;
   assign cout      = stage_q[STAGES-1].carry;
   assign ovf       = stage_q[STAGES-1].ovf;

endmodule
